// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - memory, redirect/halt and decode handshake bundle of fetch_ctrl
interface fetch_ctrl_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [1:0]  state_o;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, fault, state_o,
    input  imem_instr, redirect_valid, redirect_pc, halt_req, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, fault, state_o,
    output imem_instr, redirect_valid, redirect_pc, halt_req, out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry {pc, instr} FIFO with registered head and flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  logic [1:0]   cnt;
  fetch_entry_t e0;
  fetch_entry_t e1;
  logic         do_pop;
  logic         do_push;

  assign full    = (cnt == 2'(DEPTH));
  assign empty   = (cnt == 2'd0);
  assign head    = e0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Entry 0 is always the head; entry 1 shifts down when the head is consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case (cnt)
        2'd0: begin
          if (do_push) e0 <= din;
        end
        2'd1: begin
          if (do_push && do_pop) e0 <= din;
          else if (do_push)      e1 <= din;
        end
        default: begin
          if (do_pop) begin
            e0 <= e1;
            if (do_push) e1 <= din;
          end
        end
      endcase
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC/FSM fetch sequencer; FETCH_TRACE_EN adds simulation trace prints
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 128,
  parameter int          QDEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  localparam logic [31:0] PC_MAX = 32'(MEM_BYTES - INSTR_BYTES);

  state_t       state;
  state_t       state_nxt;
  logic [31:0]  pc;
  logic [31:0]  pc_nxt;
  logic         fault_q;
  logic         fault_nxt;
  logic         push;
  logic         flush;
  logic         pop;
  logic         q_full;
  logic         q_empty;
  logic         redirect_bad;
  fetch_entry_t q_din;
  fetch_entry_t q_head;

  assign redirect_bad = (bus.redirect_pc[1:0] != 2'b00) || (bus.redirect_pc > PC_MAX);
  assign pop          = !q_empty && bus.out_ready;
  assign q_din        = '{pc: pc, instr: bus.imem_instr};

  // Redirects outrank halt, halt outranks fetch; FAULT only drains the queue
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fault_nxt = fault_q;
    push      = 1'b0;
    flush     = 1'b0;
    case (state)
      ST_RUN, ST_HALT: begin
        if (bus.redirect_valid) begin
          flush = 1'b1;
          if (redirect_bad) begin
            state_nxt = ST_FAULT;
            fault_nxt = 1'b1;
          end else begin
            pc_nxt    = bus.redirect_pc;
            state_nxt = bus.halt_req ? ST_HALT : ST_RUN;
          end
        end else if (bus.halt_req) begin
          state_nxt = ST_HALT;
        end else if (state == ST_HALT) begin
          state_nxt = ST_RUN;
        end else if (!q_full) begin
          if (pc <= PC_MAX) begin
            push   = 1'b1;
            pc_nxt = pc + 32'(INSTR_BYTES);
          end else begin
            state_nxt = ST_FAULT;
            fault_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_FAULT;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // PC and sticky fault flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc      <= pc_nxt;
      fault_q <= fault_nxt;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (q_din),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  assign bus.imem_addr = pc;
  assign bus.out_valid = !q_empty;
  assign bus.out_instr = q_head.instr;
  assign bus.out_pc    = q_head.pc;
  assign bus.fault     = fault_q;
  assign bus.state_o   = state;

`ifdef FETCH_TRACE_EN
  // Simulation trace of pushes, accepted redirects and fault entry
  always @(posedge clk) begin
    if (!rst) begin
      if (push) $display("fetch pc=%h instr=%h", pc, bus.imem_instr);
      if (bus.redirect_valid && state != ST_FAULT) $display("redirect pc=%h", bus.redirect_pc);
      if (state != ST_FAULT && state_nxt == ST_FAULT) $display("fault entry pc=%h", pc);
    end
  end
`else
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  logic [31:0] mem [0:31];

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC  (32'h0),
    .MEM_BYTES (128),
    .QDEPTH    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Combinational instruction memory, word view of the 128-byte array
  assign bus.imem_instr = (bus.imem_addr < 32'd128) ? mem[bus.imem_addr[6:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt_req = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt_req = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.out_valid); else passed++;
    total++; if (bus.out_pc !== 32'h0) $display("FAIL reset_pc got %h exp 0", bus.out_pc); else passed++;
    total++; if (bus.out_instr !== 32'h0) $display("FAIL reset_instr got %h exp 0", bus.out_instr); else passed++;
    total++; if (bus.fault !== 1'b0) $display("FAIL reset_fault got %b exp 0", bus.fault); else passed++;
    total++; if (bus.state_o !== 2'd0) $display("FAIL reset_state got %0d exp 0", bus.state_o); else passed++;
    total++; if (bus.imem_addr !== 32'h0) $display("FAIL reset_addr got %h exp 0", bus.imem_addr); else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b1) $display("FAIL stream_v0 got %b exp 1", bus.out_valid); else passed++;
    total++; if (bus.out_pc !== 32'h0) $display("FAIL stream_pc0 got %h exp 0", bus.out_pc); else passed++;
    total++; if (bus.out_instr !== 32'h0) $display("FAIL stream_i0 got %h exp 0", bus.out_instr); else passed++;
    total++; if (bus.imem_addr !== 32'h4) $display("FAIL stream_addr got %h exp 4", bus.imem_addr); else passed++;
    tick();
    total++; if (bus.out_pc !== 32'h4) $display("FAIL stream_pc4 got %h exp 4", bus.out_pc); else passed++;
    total++; if (bus.out_instr !== 32'h0050_0093) $display("FAIL stream_i4 got %h exp 00500093", bus.out_instr); else passed++;
    tick();
    total++; if (bus.out_valid !== 1'b1) $display("FAIL stream_v8 got %b exp 1", bus.out_valid); else passed++;
    total++; if (bus.out_pc !== 32'h8) $display("FAIL stream_pc8 got %h exp 8", bus.out_pc); else passed++;
    total++; if (bus.out_instr !== 32'h0010_0393) $display("FAIL stream_i8 got %h exp 00100393", bus.out_instr); else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b0;
    repeat (5) tick();
    total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid got %b exp 1", bus.out_valid); else passed++;
    total++; if (bus.out_pc !== 32'h0) $display("FAIL bp_head got %h exp 0", bus.out_pc); else passed++;
    total++; if (bus.imem_addr !== 32'h8) $display("FAIL bp_frozen_addr got %h exp 8", bus.imem_addr); else passed++;
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_pc !== 32'h4) $display("FAIL bp_pc4 got %h exp 4", bus.out_pc); else passed++;
    total++; if (bus.imem_addr !== 32'h8) $display("FAIL bp_addr8 got %h exp 8", bus.imem_addr); else passed++;
    tick();
    total++; if (bus.out_pc !== 32'h8) $display("FAIL bp_pc8 got %h exp 8", bus.out_pc); else passed++;
    total++; if (bus.out_instr !== 32'h0010_0393) $display("FAIL bp_i8 got %h exp 00100393", bus.out_instr); else passed++;
    tick();
    total++; if (bus.out_pc !== 32'hC) $display("FAIL bp_pcC got %h exp c", bus.out_pc); else passed++;
    total++; if (bus.out_instr !== 32'hA000_0003) $display("FAIL bp_iC got %h exp a0000003", bus.out_instr); else passed++;
  endtask

  task automatic test_redirect_full();
    do_reset();
    bus.out_ready = 1'b0;
    repeat (3) tick();
    total++; if (bus.out_pc !== 32'h0) $display("FAIL rd_full_head got %h exp 0", bus.out_pc); else passed++;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h14;
    tick();
    bus.redirect_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rd_flush got %b exp 0", bus.out_valid); else passed++;
    total++; if (bus.imem_addr !== 32'h14) $display("FAIL rd_addr got %h exp 14", bus.imem_addr); else passed++;
    tick();
    total++; if (bus.out_valid !== 1'b1) $display("FAIL rd_valid got %b exp 1", bus.out_valid); else passed++;
    total++; if (bus.out_pc !== 32'h14) $display("FAIL rd_pc got %h exp 14", bus.out_pc); else passed++;
    total++; if (bus.out_instr !== 32'hA000_0005) $display("FAIL rd_instr got %h exp a0000005", bus.out_instr); else passed++;
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_pc !== 32'h18) $display("FAIL rd_next_pc got %h exp 18", bus.out_pc); else passed++;
    total++; if (bus.out_instr !== 32'hA000_0006) $display("FAIL rd_next_instr got %h exp a0000006", bus.out_instr); else passed++;
  endtask

  task automatic test_misaligned();
    do_reset();
    bus.out_ready = 1'b0;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h16;
    tick();
    bus.redirect_valid = 1'b0;
    total++; if (bus.fault !== 1'b1) $display("FAIL mis_fault got %b exp 1", bus.fault); else passed++;
    total++; if (bus.state_o !== 2'd2) $display("FAIL mis_state got %0d exp 2", bus.state_o); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL mis_valid got %b exp 0", bus.out_valid); else passed++;
    total++; if (bus.imem_addr !== 32'h4) $display("FAIL mis_pc_hold got %h exp 4", bus.imem_addr); else passed++;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h20;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    bus.redirect_valid = 1'b0;
    total++; if (bus.state_o !== 2'd2) $display("FAIL mis_sticky_state got %0d exp 2", bus.state_o); else passed++;
    total++; if (bus.fault !== 1'b1) $display("FAIL mis_sticky_fault got %b exp 1", bus.fault); else passed++;
    total++; if (bus.imem_addr !== 32'h4) $display("FAIL mis_ignore_rd got %h exp 4", bus.imem_addr); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL mis_no_push got %b exp 0", bus.out_valid); else passed++;
    rst = 1'b1;
    #1;
    total++; if (bus.fault !== 1'b0) $display("FAIL mis_rst_fault got %b exp 0", bus.fault); else passed++;
    total++; if (bus.state_o !== 2'd0) $display("FAIL mis_rst_state got %0d exp 0", bus.state_o); else passed++;
    total++; if (bus.imem_addr !== 32'h0) $display("FAIL mis_rst_addr got %h exp 0", bus.imem_addr); else passed++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_seq_fault();
    do_reset();
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h74;
    tick();
    bus.redirect_valid = 1'b0;
    total++; if (bus.imem_addr !== 32'h74) $display("FAIL sf_addr got %h exp 74", bus.imem_addr); else passed++;
    tick();
    total++; if (bus.out_pc !== 32'h74) $display("FAIL sf_pc74 got %h exp 74", bus.out_pc); else passed++;
    tick();
    total++; if (bus.out_pc !== 32'h78) $display("FAIL sf_pc78 got %h exp 78", bus.out_pc); else passed++;
    tick();
    total++; if (bus.out_pc !== 32'h7C) $display("FAIL sf_pc7c got %h exp 7c", bus.out_pc); else passed++;
    total++; if (bus.out_instr !== 32'hA000_001F) $display("FAIL sf_i7c got %h exp a000001f", bus.out_instr); else passed++;
    total++; if (bus.fault !== 1'b0) $display("FAIL sf_early_fault got %b exp 0", bus.fault); else passed++;
    tick();
    total++; if (bus.fault !== 1'b1) $display("FAIL sf_fault got %b exp 1", bus.fault); else passed++;
    total++; if (bus.state_o !== 2'd2) $display("FAIL sf_state got %0d exp 2", bus.state_o); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL sf_no_push80 got %b exp 0", bus.out_valid); else passed++;
    total++; if (bus.imem_addr !== 32'h80) $display("FAIL sf_addr80 got %h exp 80", bus.imem_addr); else passed++;
  endtask

  task automatic test_halt();
    do_reset();
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.halt_req = 1'b1;
    tick();
    total++; if (bus.state_o !== 2'd1) $display("FAIL halt_state got %0d exp 1", bus.state_o); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL halt_drain got %b exp 0", bus.out_valid); else passed++;
    tick();
    tick();
    total++; if (bus.imem_addr !== 32'h8) $display("FAIL halt_addr got %h exp 8", bus.imem_addr); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL halt_nopush got %b exp 0", bus.out_valid); else passed++;
    bus.halt_req = 1'b0;
    tick();
    total++; if (bus.state_o !== 2'd0) $display("FAIL halt_resume got %0d exp 0", bus.state_o); else passed++;
    tick();
    total++; if (bus.out_pc !== 32'h8) $display("FAIL halt_next_pc got %h exp 8", bus.out_pc); else passed++;
    total++; if (bus.out_instr !== 32'h0010_0393) $display("FAIL halt_next_i got %h exp 00100393", bus.out_instr); else passed++;
  endtask

  task automatic test_redirect_halt();
    bus.halt_req = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    total++; if (bus.state_o !== 2'd1) $display("FAIL rh_state got %0d exp 1", bus.state_o); else passed++;
    total++; if (bus.imem_addr !== 32'h40) $display("FAIL rh_addr got %h exp 40", bus.imem_addr); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rh_flush got %b exp 0", bus.out_valid); else passed++;
    bus.halt_req = 1'b0;
    tick();
    tick();
    total++; if (bus.out_pc !== 32'h40) $display("FAIL rh_pc got %h exp 40", bus.out_pc); else passed++;
    total++; if (bus.out_instr !== 32'hA000_0010) $display("FAIL rh_instr got %h exp a0000010", bus.out_instr); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[0] = 32'h0000_0000;
    mem[1] = 32'h0050_0093;
    mem[2] = 32'h0010_0393;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_misaligned();
    test_seq_fault();
    test_halt();
    test_redirect_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
